// File: rtl/jam_scheduler.sv
// Round-robin jam-slot scheduler: grants one requesting lane per slot,
// slot length counted in ticks and latched at each grant.
module jam_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 4,
  parameter int LANE_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 tick,
  input  logic [NUM_LANES-1:0] jam_req,
  input  logic [CNT_W-1:0]     slot_len,
  output logic [LANE_W-1:0]    active_lane,
  output logic                 active_valid,
  output logic                 jam_start,
  output logic                 jam_rotation,
  output logic [CNT_W-1:0]     elapsed
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [LANE_W-1:0] PTR_RST = LANE_W'(NUM_LANES - 1);

  state_t              state;
  logic [LANE_W-1:0]   ptr;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    last;
  logic                expire;
  logic                nxt_found;
  logic [LANE_W-1:0]   nxt_lane;
  int                  idx;

  // Zero-length slots behave as one-tick slots.
  assign last   = (len_q == '0) ? '0 : len_q - CNT_W'(1);
  assign expire = tick && (elapsed == last);

  always_comb begin
    nxt_found = 1'b0;
    nxt_lane  = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = (int'(ptr) + k) % NUM_LANES;
      if (!nxt_found && jam_req[idx]) begin
        nxt_found = 1'b1;
        nxt_lane  = LANE_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= PTR_RST;
      len_q        <= '0;
      active_lane  <= '0;
      active_valid <= 1'b0;
      jam_start    <= 1'b0;
      jam_rotation <= 1'b0;
      elapsed      <= '0;
    end else if (!en) begin
      state        <= IDLE;
      ptr          <= PTR_RST;
      len_q        <= '0;
      active_lane  <= '0;
      active_valid <= 1'b0;
      jam_start    <= 1'b0;
      jam_rotation <= 1'b0;
      elapsed      <= '0;
    end else begin
      jam_start    <= 1'b0;
      jam_rotation <= 1'b0;
      unique case (state)
        IDLE: begin
          if (nxt_found) begin
            state        <= RUN;
            ptr          <= nxt_lane;
            len_q        <= slot_len;
            active_lane  <= nxt_lane;
            active_valid <= 1'b1;
            jam_start    <= 1'b1;
            elapsed      <= '0;
          end
        end
        RUN: begin
          if (expire) begin
            jam_rotation <= 1'b1;
            elapsed      <= '0;
            if (nxt_found) begin
              ptr          <= nxt_lane;
              len_q        <= slot_len;
              active_lane  <= nxt_lane;
              jam_start    <= 1'b1;
            end else begin
              state        <= IDLE;
              active_lane  <= '0;
              active_valid <= 1'b0;
            end
          end else if (tick) begin
            elapsed <= elapsed + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_scheduler.sv
// Directed bench for jam_scheduler: vector table plus
// hand-written reset, single-lane and abort sequences.
module tb_jam_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] jam_req = '0;
  logic [3:0] slot_len = '0;
  logic [1:0] active_lane;
  logic       active_valid;
  logic       jam_start;
  logic       jam_rotation;
  logic [3:0] elapsed;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       en;
    logic       tick;
    logic [3:0] req;
    logic [3:0] len;
    logic       valid;
    logic [1:0] lane;
    logic       start;
    logic       rot;
    logic [3:0] el;
  } vec_t;

  vec_t tbl[$];

  jam_scheduler #(
    .NUM_LANES(4),
    .CNT_W(4),
    .LANE_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .tick(tick),
    .jam_req(jam_req),
    .slot_len(slot_len),
    .active_lane(active_lane),
    .active_valid(active_valid),
    .jam_start(jam_start),
    .jam_rotation(jam_rotation),
    .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic v, input logic [1:0] l,
                         input logic s, input logic r, input logic [3:0] e);
    chk({name, ".valid"}, int'(active_valid), int'(v));
    chk({name, ".lane"}, int'(active_lane), int'(l));
    chk({name, ".start"}, int'(jam_start), int'(s));
    chk({name, ".rot"}, int'(jam_rotation), int'(r));
    chk({name, ".elapsed"}, int'(elapsed), int'(e));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, input logic t, input logic [3:0] q,
                     input logic [3:0] ln, input logic v, input logic [1:0] l,
                     input logic s, input logic r, input logic [3:0] el);
    vec_t x;
    x.en = e; x.tick = t; x.req = q; x.len = ln;
    x.valid = v; x.lane = l; x.start = s; x.rot = r; x.el = el;
    tbl.push_back(x);
  endtask

  initial begin
    // round robin 0,1,3,0,1 with 3-tick slots
    add(1, 1, 4'b1011, 3, 1, 0, 1, 0, 0);
    add(1, 1, 4'b1011, 3, 1, 0, 0, 0, 1);
    add(1, 1, 4'b1011, 3, 1, 0, 0, 0, 2);
    add(1, 1, 4'b1011, 3, 1, 1, 1, 1, 0);
    add(1, 1, 4'b1011, 3, 1, 1, 0, 0, 1);
    add(1, 1, 4'b1011, 3, 1, 1, 0, 0, 2);
    add(1, 1, 4'b1011, 3, 1, 3, 1, 1, 0);
    add(1, 1, 4'b1011, 3, 1, 3, 0, 0, 1);
    add(1, 1, 4'b1011, 3, 1, 3, 0, 0, 2);
    add(1, 1, 4'b1011, 3, 1, 0, 1, 1, 0);
    add(1, 1, 4'b1011, 3, 1, 0, 0, 0, 1);
    add(1, 1, 4'b1011, 3, 1, 0, 0, 0, 2);
    add(1, 1, 4'b1011, 3, 1, 1, 1, 1, 0);
    // drain with tick every 4th cycle
    add(1, 0, 4'b0000, 3, 1, 1, 0, 0, 0);
    add(1, 0, 4'b0000, 3, 1, 1, 0, 0, 0);
    add(1, 0, 4'b0000, 3, 1, 1, 0, 0, 0);
    add(1, 1, 4'b0000, 3, 1, 1, 0, 0, 1);
    add(1, 0, 4'b0000, 3, 1, 1, 0, 0, 1);
    add(1, 0, 4'b0000, 3, 1, 1, 0, 0, 1);
    add(1, 0, 4'b0000, 3, 1, 1, 0, 0, 1);
    add(1, 1, 4'b0000, 3, 1, 1, 0, 0, 2);
    add(1, 0, 4'b0000, 3, 1, 1, 0, 0, 2);
    add(1, 0, 4'b0000, 3, 1, 1, 0, 0, 2);
    add(1, 0, 4'b0000, 3, 1, 1, 0, 0, 2);
    add(1, 1, 4'b0000, 3, 0, 0, 0, 1, 0);
    add(1, 1, 4'b0000, 3, 0, 0, 0, 0, 0);
    // slot_len 0 behaves as 1 tick
    add(1, 1, 4'b0001, 0, 1, 0, 1, 0, 0);
    add(1, 1, 4'b0001, 0, 1, 0, 1, 1, 0);
    add(1, 1, 4'b0001, 0, 1, 0, 1, 1, 0);
    add(1, 1, 4'b0000, 0, 0, 0, 0, 1, 0);
    // slot_len change mid-slot ignored
    add(1, 0, 4'b0100, 2, 1, 2, 1, 0, 0);
    add(1, 1, 4'b0100, 9, 1, 2, 0, 0, 1);
    add(1, 1, 4'b0100, 9, 1, 2, 1, 1, 0);
    add(1, 1, 4'b0100, 5, 1, 2, 0, 0, 1);
    add(1, 1, 4'b0100, 5, 1, 2, 0, 0, 2);
    // en low clears without a rotation pulse
    add(0, 1, 4'b0100, 5, 0, 0, 0, 0, 0);

    #12;
    chk_all("reset", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk_all("idle20", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    end

    // single lane, 15-tick slot, re-grant of the same lane
    jam_req = 4'b0100;
    slot_len = 4'd15;
    cyc();
    chk_all("single.grant", 1'b1, 2'd2, 1'b1, 1'b0, 4'd0);
    for (int i = 1; i < 15; i++) begin
      cyc();
      chk_all("single.run", 1'b1, 2'd2, 1'b0, 1'b0, 4'(i));
    end
    cyc();
    chk_all("single.regrant", 1'b1, 2'd2, 1'b1, 1'b1, 4'd0);
    en = 1'b0;
    cyc();
    chk_all("single.clear", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);

    foreach (tbl[i]) begin
      en = tbl[i].en;
      tick = tbl[i].tick;
      jam_req = tbl[i].req;
      slot_len = tbl[i].len;
      cyc();
      chk_all($sformatf("vec%0d", i), tbl[i].valid, tbl[i].lane,
              tbl[i].start, tbl[i].rot, tbl[i].el);
    end

    // en abort at elapsed 7
    en = 1'b1;
    tick = 1'b1;
    jam_req = 4'b0110;
    slot_len = 4'd15;
    cyc();
    chk_all("enab.grant", 1'b1, 2'd1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) cyc();
    jam_req = 4'b0100;
    cyc();
    chk_all("enab.el7", 1'b1, 2'd1, 1'b0, 1'b0, 4'd7);
    jam_req = 4'b0110;
    en = 1'b0;
    cyc();
    chk_all("enab.clear", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    en = 1'b1;
    tick = 1'b0;
    cyc();
    chk_all("enab.restart", 1'b1, 2'd1, 1'b1, 1'b0, 4'd0);

    // async reset abort at elapsed 7
    tick = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    chk_all("rst.el7", 1'b1, 2'd1, 1'b0, 1'b0, 4'd7);
    rst_n = 1'b0;
    #1;
    chk_all("rst.async", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    cyc();
    chk_all("rst.hold", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all("rst.release", 1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
    cyc();
    chk_all("rst.restart", 1'b1, 2'd1, 1'b1, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jam_scheduler.md
JAM_SCHEDULER -- requirements
Module: jam_scheduler

Interface
REQ-001 Parameter NUM_LANES, default 4: number of lanes competing for jam service; legal range 2..16.
REQ-002 Parameter CNT_W, default 4: width of the slot counter and the slot_len input.
REQ-003 Parameter LANE_W, default 2: width of the lane index; it SHALL equal clog2(NUM_LANES).
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  scheduler enable; low means synchronous clear.
REQ-007 tick  in  1  one-cycle time-base strobe (1 s); the slot counter advances only on tick.
REQ-008 jam_req  in  NUM_LANES  per-lane jam-detected level; bit i is lane i.
REQ-009 slot_len  in  CNT_W  slot length in ticks, sampled at each grant.
REQ-010 active_lane  out  LANE_W  index of the lane currently granted; 0 when not valid.
REQ-011 active_valid  out  1  a lane is currently granted.
REQ-012 jam_start  out  1  one-cycle pulse in the first cycle of every grant.
REQ-013 jam_rotation  out  1  one-cycle pulse in the cycle a slot expires.
REQ-014 elapsed  out  CNT_W  ticks elapsed in the current slot.

Function
REQ-015 The block SHALL implement the FSM states IDLE and RUN, with all outputs registered.
REQ-016 In IDLE with en=1 and jam_req!=0, the block SHALL grant at the next edge and go to RUN.
- Grant effects: active_valid=1, active_lane=selected lane, jam_start=1 for that one cycle, elapsed=0, slot_len latched.
REQ-017 Lane selection SHALL be round-robin.
- Search lanes ptr+1, ptr+2, … wrapping modulo NUM_LANES, where ptr is the last granted lane.
- First set bit wins; after reset ptr=NUM_LANES-1, so lane 0 has first priority.
REQ-018 In RUN, on each cycle with tick=1 and elapsed != L-1, elapsed SHALL increment by 1.
- L is the latched slot length; a latched value of 0 SHALL be treated as 1.
REQ-019 In RUN, on a cycle with tick=1 and elapsed == L-1, the slot expires.
- At the next edge: jam_rotation=1 for one cycle, elapsed=0.
- The next lane is selected per REQ-017 using the jam_req value of the expiry cycle.
REQ-020 On expiry with a lane found, that lane SHALL be granted in the same edge as jam_rotation.
- jam_start and jam_rotation are both 1 in that cycle; the block stays in RUN.
- If the only requesting lane is the current one, it SHALL be re-granted.
REQ-021 On expiry with jam_req==0, the block SHALL go to IDLE.
- At that edge: active_valid=0, active_lane=0, jam_rotation=1, jam_start=0.
REQ-022 A slot SHALL NOT be pre-empted: deasserting the granted lane's jam_req mid-slot has no effect until expiry.
REQ-023 Changes to slot_len mid-slot SHALL have no effect until the next grant.
REQ-024 With tick=0 all state SHALL hold in RUN; jam_start and jam_rotation return to 0 after their pulse cycle.
REQ-025 elapsed SHALL never exceed L-1 and SHALL never wrap through 2^CNT_W.

Reset
REQ-026 While rst_n=0, the block SHALL be in IDLE with all outputs 0, elapsed=0, and ptr=NUM_LANES-1.
REQ-027 en=0 at any edge, including mid-slot, SHALL apply the REQ-026 state synchronously.
- No jam_rotation pulse is emitted.
- On re-enable, arbitration restarts from lane 0.
REQ-028 Asserting rst_n mid-slot SHALL abort the slot immediately with no residual pulses after release.

Verification
REQ-029 Reset state: after reset release with en=1, jam_req=4'b0000 for 20 cycles -> active_valid=0, no pulses, elapsed=0.
REQ-030 Single-lane service and re-grant.
- Stimulus: slot_len=15, jam_req=4'b0100, tick every cycle.
- Expected: jam_start one cycle after en; active_lane=2; jam_rotation 15 ticks later together with jam_start; active_lane still 2.
REQ-031 Round-robin.
- Stimulus: jam_req=4'b1011, slot_len=3.
- Expected grant order 0,1,3,0,1; exactly 3 ticks per slot; rotation and start coincide at each boundary.
REQ-032 Drain to IDLE and tick gating.
- Stimulus: drop jam_req to 0 mid-slot, with tick every 4th cycle.
- Expected: slot completes its full length; on expiry jam_rotation=1, active_valid=0, state is IDLE.
REQ-033 Boundaries: slot_len=0 gives 1-tick slots; changing slot_len mid-slot leaves the current slot length unchanged.
REQ-034 Abort mid-slot.
- Stimulus: en=0 at elapsed=7; separately, rst_n=0 at elapsed=7.
- Expected: all outputs 0 next edge (en) or immediately (rst_n); no jam_rotation; next grant goes to the lowest requesting lane.
